// File: rtl/spi_reg_peripheral_if.sv
// SPI pin bundle between an SPI controller (master) and the register peripheral (slave).
// Write-only link: no CIPO line.
interface spi_reg_peripheral_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register peripheral: synchronises the SPI pins into clk,
// deserialises 16-bit frames and commits valid writes into a small register bank.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_peripheral_if.slave  spi,
  output logic [7:0]           en_reg_out_7_0,
  output logic [7:0]           en_reg_out_15_8,
  output logic [7:0]           en_reg_pwm_7_0,
  output logic [7:0]           en_reg_pwm_15_8,
  output logic [7:0]           pwm_duty_cycle,
  output logic                 wr_strobe,
  output logic [6:0]           wr_addr
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                  r_sclk_d;
  logic                  r_ncs_d;
  logic [FRAME_W-1:0]    r_shift;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_sclk_s;
  logic                  w_copi_s;
  logic                  w_ncs_s;
  logic                  w_sclk_rise;
  logic                  w_ncs_rise;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_data;
  logic                  w_wr_ok;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
  assign w_addr      = r_shift[FRAME_W-2 -: ADDR_W];
  assign w_data      = r_shift[DATA_W-1:0];
  // Only an exact 16-bit write frame to an implemented address is committed.
  assign w_wr_ok     = (r_cnt == CNT_FULL) && r_shift[FRAME_W-1]
                       && (w_addr < ADDR_W'(NUM_REGS));

  // Pin synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '0;
      r_sclk_d    <= 1'b0;
      r_ncs_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.ncs};
      r_sclk_d    <= w_sclk_s;
      r_ncs_d     <= w_ncs_s;
    end
  end

  // Frame FSM and register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_shift         <= '0;
      r_cnt           <= '0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      wr_addr         <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_ncs_s) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_ncs_rise) begin
            r_state <= COMMIT;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_copi_s};
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          if (w_wr_ok) begin
            wr_strobe <= 1'b1;
            wr_addr   <= w_addr;
            case (w_addr)
              7'd0:    en_reg_out_7_0  <= w_data;
              7'd1:    en_reg_out_15_8 <= w_data;
              7'd2:    en_reg_pwm_7_0  <= w_data;
              7'd3:    en_reg_pwm_15_8 <= w_data;
              7'd4:    pwm_duty_cycle  <= w_data;
              default: ;
            endcase
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: table of SPI frames with expected register
// bank state, plus hand-written mid-frame reset and back-to-back write sequences.
module tb_spi_reg_peripheral;

  logic       clk;
  logic       rst;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic [6:0] wr_addr;

  spi_reg_peripheral_if spi_bus ();

  spi_reg_peripheral #(
    .SYNC_STAGES (2),
    .NUM_REGS    (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .spi             (spi_bus.slave),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .wr_addr         (wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int strobe_pulses = 0;
  int strobe_cycles = 0;
  logic strobe_prev = 1'b0;

  // Strobe activity sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cycles = strobe_cycles + 1;
      if (strobe_prev !== 1'b1) strobe_pulses = strobe_pulses + 1;
    end
    strobe_prev = wr_strobe;
  end

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [39:0] exp_regs;   // {reg4, reg3, reg2, reg1, reg0}
    int          exp_pulses;
    logic [6:0]  exp_addr;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] regs_now();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  task automatic check_regs(input string tag, input logic [39:0] exp);
    logic [39:0] act;
    act = regs_now();
    for (int r = 0; r < 5; r++) begin
      check($sformatf("%s reg%0d", tag, r), 32'(act[r*8 +: 8]), 32'(exp[r*8 +: 8]));
    end
  endtask

  task automatic send_bits(input logic [31:0] f, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      spi_bus.copi = f[b];
      tick(4);
      spi_bus.sclk = 1'b1;
      tick(4);
      spi_bus.sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input int nbits, input int gap);
    spi_bus.ncs = 1'b0;
    tick(4);
    send_bits(f, nbits - 1, 0);
    tick(4);
    spi_bus.ncs = 1'b1;
    tick(gap);
  endtask

  initial begin
    int p0;

    vecs[0] = '{32'h80F0,  16, 40'h00_00_00_00_F0, 1, 7'h00};
    vecs[1] = '{32'h8480,  16, 40'h80_00_00_00_F0, 1, 7'h04};
    vecs[2] = '{32'h8555,  16, 40'h80_00_00_00_F0, 0, 7'h04};
    vecs[3] = '{32'h00AA,  16, 40'h80_00_00_00_F0, 0, 7'h04};
    vecs[4] = '{32'h0812,  12, 40'h80_00_00_00_F0, 0, 7'h04};
    vecs[5] = '{32'h103FF, 17, 40'h80_00_00_00_F0, 0, 7'h04};

    rst          = 1'b1;
    spi_bus.sclk = 1'b0;
    spi_bus.copi = 1'b0;
    spi_bus.ncs  = 1'b1;
    tick(4);
    check_regs("reset", 40'h0);
    check("reset wr_strobe", 32'(wr_strobe), 32'h0);
    check("reset wr_addr", 32'(wr_addr), 32'h0);
    rst = 1'b0;
    tick(8);

    for (int v = 0; v < 6; v++) begin
      p0 = strobe_pulses;
      send_frame(vecs[v].frame, vecs[v].nbits, 10);
      check_regs($sformatf("vec%0d", v), vecs[v].exp_regs);
      check($sformatf("vec%0d strobes", v), 32'(strobe_pulses - p0), 32'(vecs[v].exp_pulses));
      check($sformatf("vec%0d wr_addr", v), 32'(wr_addr), 32'(vecs[v].exp_addr));
    end

    // Reset lands mid-frame; the tail of that frame must be discarded.
    spi_bus.ncs = 1'b0;
    tick(4);
    send_bits(32'h83CC, 15, 8);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_regs("midrst", 40'h0);
    check("midrst wr_addr", 32'(wr_addr), 32'h0);
    p0 = strobe_pulses;
    send_bits(32'h83CC, 7, 0);
    tick(4);
    spi_bus.ncs = 1'b1;
    tick(10);
    check_regs("midrst tail", 40'h0);
    check("midrst tail strobes", 32'(strobe_pulses - p0), 32'h0);
    send_frame(32'h83CC, 16, 10);
    check_regs("after rst", 40'h00_CC_00_00_00);
    check("after rst strobes", 32'(strobe_pulses - p0), 32'h1);
    check("after rst wr_addr", 32'(wr_addr), 32'h3);

    // Back-to-back writes with the minimum nCS high gap.
    p0 = strobe_pulses;
    send_frame(32'h8011, 16, 4);
    send_frame(32'h8122, 16, 4);
    send_frame(32'h8233, 16, 4);
    send_frame(32'h8344, 16, 4);
    send_frame(32'h8455, 16, 10);
    check_regs("b2b", 40'h55_44_33_22_11);
    check("b2b strobes", 32'(strobe_pulses - p0), 32'h5);
    check("b2b wr_addr", 32'(wr_addr), 32'h4);

    // Same-value rewrite still pulses the strobe.
    p0 = strobe_pulses;
    send_frame(32'h8455, 16, 10);
    check("rewrite strobes", 32'(strobe_pulses - p0), 32'h1);
    check_regs("rewrite", 40'h55_44_33_22_11);

    check("strobe width", 32'(strobe_cycles), 32'(strobe_pulses));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
